// File: rtl/ex_pkg.sv
// ex_pkg: shared definitions for the EX-stage sequencer.
//   op_e          op class carried on in_op
//   Alu*          ALUctr encodings driven to the EX ALU
//   Asrc*/Bsrc*   ALUASrc / ALUBSrc operand selects
//   state_e       sequencer states
//   op_to_alu_ctl decode of an op class into its ALU controls
package ex_pkg;

  typedef enum logic [3:0] {
    OpAdd  = 4'd0,
    OpSub  = 4'd1,
    OpSlt  = 4'd2,
    OpSltu = 4'd3,
    OpOr   = 4'd4,
    OpAddi = 4'd5,
    OpOri  = 4'd6,
    OpLui  = 4'd7,
    OpJal  = 4'd8,
    OpBeq  = 4'd9,
    OpMul  = 4'd10
  } op_e;

  localparam logic [3:0] AluAdd   = 4'b0000;
  localparam logic [3:0] AluSub   = 4'b1000;
  localparam logic [3:0] AluSlt   = 4'b0010;
  localparam logic [3:0] AluSltu  = 4'b0011;
  localparam logic [3:0] AluOr    = 4'b0110;
  localparam logic [3:0] AluPassB = 4'b1111;

  localparam logic       AsrcBusA = 1'b0;
  localparam logic       AsrcPc   = 1'b1;
  localparam logic [1:0] BsrcBusB = 2'b00;
  localparam logic [1:0] BsrcFour = 2'b01;
  localparam logic [1:0] BsrcImm  = 2'b10;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAlu  = 2'd1,
    StMul  = 2'd2,
    StHold = 2'd3
  } state_e;

  typedef struct packed {
    logic [3:0] ctr;
    logic       asrc;
    logic [1:0] bsrc;
  } alu_ctl_t;

  function automatic alu_ctl_t op_to_alu_ctl(op_e op);
    alu_ctl_t c;
    c = '{ctr: AluAdd, asrc: AsrcBusA, bsrc: BsrcBusB};
    case (op)
      OpAdd:   c = '{ctr: AluAdd,   asrc: AsrcBusA, bsrc: BsrcBusB};
      OpSub:   c = '{ctr: AluSub,   asrc: AsrcBusA, bsrc: BsrcBusB};
      OpSlt:   c = '{ctr: AluSlt,   asrc: AsrcBusA, bsrc: BsrcBusB};
      OpSltu:  c = '{ctr: AluSltu,  asrc: AsrcBusA, bsrc: BsrcBusB};
      OpOr:    c = '{ctr: AluOr,    asrc: AsrcBusA, bsrc: BsrcBusB};
      OpAddi:  c = '{ctr: AluAdd,   asrc: AsrcBusA, bsrc: BsrcImm};
      OpOri:   c = '{ctr: AluOr,    asrc: AsrcBusA, bsrc: BsrcImm};
      OpLui:   c = '{ctr: AluPassB, asrc: AsrcBusA, bsrc: BsrcImm};
      OpJal:   c = '{ctr: AluAdd,   asrc: AsrcPc,   bsrc: BsrcFour};
      OpBeq:   c = '{ctr: AluSub,   asrc: AsrcBusA, bsrc: BsrcBusB};
      default: ; // MUL does not use the ALU
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ex_mul_iter.sv
// ex_mul_iter: fixed-latency shift-and-add multiplier, one bit per cycle.
//   clk, rst            clock, asynchronous active-high reset (aborts the op)
//   start               load mcand_in/mplier_in, clear acc and cnt
//   mcand_in, mplier_in operands
//   busy                iterating
//   done                final iteration this cycle; product is valid now
//   product             accumulator value after this cycle's add (low XLEN bits)
module ex_mul_iter #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned ITERS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] mcand_in,
  input  logic [XLEN-1:0] mplier_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] product
);

  localparam int unsigned CntW = (ITERS > 1) ? $clog2(ITERS) : 1;

  logic [XLEN-1:0] r_acc, r_mcand, r_mplier;
  logic [CntW-1:0] r_cnt;
  logic            r_busy;
  logic [XLEN-1:0] w_acc_next;

  assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign busy       = r_busy;
  assign done       = r_busy && (r_cnt == CntW'(ITERS - 1));
  // Exposed combinationally so the last add lands in the result on the done edge.
  assign product    = w_acc_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (start) begin
      r_acc    <= '0;
      r_mcand  <= mcand_in;
      r_mplier <= mplier_in;
      r_cnt    <= '0;
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CntW'(1);
      if (done) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/ex_ctrl.sv
// ex_ctrl: EX-stage sequencer. Holds the ID/EX register, drives the external ALU,
// resolves BEQ/JAL redirects, runs the iterative MUL and hands results to MEM.
//   clk, rst                         clock, asynchronous active-high reset
//   in_valid/in_ready, in_*          op from ID (op class, pc, operands, rd)
//   alu_ctr/asrc/bsrc, alu_pc..imm   registered controls and operands to the ALU
//   alu_out/alu_zero/alu_target      ALU results sampled in the ALU state
//   out_valid/out_ready, out_*       result handshake to MEM
//   redirect, redirect_pc            one-cycle taken-branch/jump pulse
module ex_ctrl
  import ex_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned MUL_ITERS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_op,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_busA,
  input  logic [XLEN-1:0] in_busB,
  input  logic [XLEN-1:0] in_imm,
  input  logic [4:0]      in_rd,
  output logic [3:0]      alu_ctr,
  output logic            alu_asrc,
  output logic [1:0]      alu_bsrc,
  output logic [XLEN-1:0] alu_pc,
  output logic [XLEN-1:0] alu_busA,
  output logic [XLEN-1:0] alu_busB,
  output logic [XLEN-1:0] alu_imm,
  input  logic [XLEN-1:0] alu_out,
  input  logic            alu_zero,
  input  logic [XLEN-1:0] alu_target,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd,
  output logic            out_we,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc
);

  state_e          r_state;
  op_e             r_op;
  alu_ctl_t        r_ctl;
  logic [XLEN-1:0] r_pc, r_busA, r_busB, r_imm;
  logic [XLEN-1:0] r_result, r_redirect_pc;
  logic [4:0]      r_rd;
  logic            r_we, r_redirect;

  op_e             w_in_op;
  alu_ctl_t        w_in_ctl;
  logic            w_in_ready, w_accept, w_mul_start;
  logic            w_mul_busy, w_mul_done;
  logic [XLEN-1:0] w_mul_product;

  assign w_in_op     = op_e'(in_op);
  assign w_in_ctl    = op_to_alu_ctl(w_in_op);
  assign w_accept    = in_valid && w_in_ready;
  assign w_mul_start = w_accept && (w_in_op == OpMul);

  always_comb begin
    w_in_ready = 1'b0;
    unique case (r_state)
      StIdle:  w_in_ready = 1'b1;
      StHold:  w_in_ready = out_ready;
      default: w_in_ready = 1'b0;
    endcase
    // Hold off ID during reset, during the redirect pulse (the op in ID is on the
    // wrong path) and while the multiplier still owns the stage.
    if (rst || r_redirect || w_mul_busy) w_in_ready = 1'b0;
  end

  ex_mul_iter #(
    .XLEN (XLEN),
    .ITERS(MUL_ITERS)
  ) u_mul (
    .clk      (clk),
    .rst      (rst),
    .start    (w_mul_start),
    .mcand_in (in_busA),
    .mplier_in(in_busB),
    .busy     (w_mul_busy),
    .done     (w_mul_done),
    .product  (w_mul_product)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= StIdle;
      r_op          <= OpAdd;
      r_ctl         <= '0;
      r_pc          <= '0;
      r_busA        <= '0;
      r_busB        <= '0;
      r_imm         <= '0;
      r_result      <= '0;
      r_redirect_pc <= '0;
      r_rd          <= '0;
      r_we          <= 1'b0;
      r_redirect    <= 1'b0;
    end else begin
      r_redirect <= 1'b0;
      unique case (r_state)
        StAlu: begin
          r_result      <= alu_out;
          r_redirect_pc <= alu_target;
          r_redirect    <= (r_op == OpJal) || ((r_op == OpBeq) && alu_zero);
          r_state       <= StHold;
        end
        StMul: begin
          if (w_mul_done) begin
            r_result <= w_mul_product;
            r_state  <= StHold;
          end
        end
        StHold: begin
          if (out_ready) r_state <= StIdle;
        end
        default: ;
      endcase
      // Accept is only possible in IDLE or in a draining HOLD, so this overrides
      // the HOLD->IDLE step when a new op arrives on the drain edge.
      if (w_accept) begin
        r_op    <= w_in_op;
        r_ctl   <= w_in_ctl;
        r_pc    <= in_pc;
        r_busA  <= in_busA;
        r_busB  <= in_busB;
        r_imm   <= in_imm;
        r_rd    <= in_rd;
        r_we    <= (w_in_op != OpBeq) && (in_rd != 5'd0);
        r_state <= (w_in_op == OpMul) ? StMul : StAlu;
      end
    end
  end

  assign in_ready    = w_in_ready;
  assign alu_ctr     = r_ctl.ctr;
  assign alu_asrc    = r_ctl.asrc;
  assign alu_bsrc    = r_ctl.bsrc;
  assign alu_pc      = r_pc;
  assign alu_busA    = r_busA;
  assign alu_busB    = r_busB;
  assign alu_imm     = r_imm;
  assign out_valid   = (r_state == StHold);
  assign out_result  = r_result;
  assign out_rd      = r_rd;
  assign out_we      = r_we;
  assign redirect    = r_redirect;
  assign redirect_pc = r_redirect_pc;

endmodule

// File: doc/ex_ctrl.md
# ex_ctrl

EX-stage sequencer for the pipelined CPU. Holds the ID/EX register, drives the control inputs of the EX ALU (`ALUctr`, `ALUASrc`, `ALUBSrc`) and samples its `ALUout`/`Zero`/`Target` outputs. Resolves BEQ/JAL redirects and runs a fixed-latency 32-cycle iterative MUL, stalling ID while busy. Hands results to MEM over a valid/ready handshake.

## Interface
- `XLEN`, 32: datapath width; only 32 is supported.
- `MUL_ITERS`, 32: MUL iteration count; must equal `XLEN`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  ID/EX holds a decoded op.
- `in_ready`  out  1  ex_ctrl accepts this cycle.
- `in_op`  in  4  op class, from `ex_pkg`.
- `in_pc`, `in_busA`, `in_busB`, `in_imm`  in  32 each  operands.
- `in_rd`  in  5  destination register.
- `alu_ctr`  out  4  to ALU `ALUctr`.
- `alu_asrc`  out  1  to ALU `ALUASrc`.
- `alu_bsrc`  out  2  to ALU `ALUBSrc`.
- `alu_pc`, `alu_busA`, `alu_busB`, `alu_imm`  out  32 each  registered operands to the ALU.
- `alu_out`  in  32  ALU result (combinational from the outputs above).
- `alu_zero`  in  1  ALU Zero.
- `alu_target`  in  32  ALU `PC+imm`.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  MEM accepts.
- `out_result`  out  32  result.
- `out_rd`  out  5  destination register.
- `out_we`  out  1  register write enable.
- `redirect`  out  1  one-cycle taken-branch/jump pulse.
- `redirect_pc`  out  32  new fetch PC.

## Operation
- Ops and their ALU controls (ctr/asrc/bsrc):
  - ADD: 0000/0/00.
  - SUB: 1000/0/00.
  - SLT: 0010/0/00.
  - SLTU: 0011/0/00.
  - OR: 0110/0/00.
  - ADDI: 0000/0/10.
  - ORI: 0110/0/10.
  - LUI: 1111/0/10.
  - JAL: 0000/1/01, result is PC+4.
  - BEQ: 1000/0/00.
  - MUL: ALU unused.
- State machine:
  - IDLE: `in_ready`=1. On accept, capture all `in_*`. MUL goes to MUL with cnt=0, acc=0, mcand=busA, mplier=busB. Every other op goes to ALU.
  - ALU: registered controls and operands are presented to the ALU. At the clock edge, latch `alu_out` into `out_result`, latch `alu_target`, and evaluate `taken`. `taken` is JAL, or BEQ with `alu_zero`=1. Next state is HOLD.
  - MUL: each cycle, if mplier[0] then acc += mcand (mod 2^32); then mcand <<= 1, mplier >>= 1, cnt++. When cnt==MUL_ITERS-1, latch the final acc as `out_result` and go to HOLD.
  - HOLD: `out_valid`=1. On `out_ready`, go to the state selected by a concurrently accepted op, or to IDLE if none.
- `in_ready` by state: 1 in IDLE; equal to `out_ready` in HOLD; 0 in ALU and MUL. It is forced to 0 in any cycle where `redirect`=1.
- `out_we`=0 for BEQ and when `out_rd`=0; otherwise 1.
- `redirect`=1 only in the first HOLD cycle of a taken op, with `redirect_pc` = latched target. The pulse is not repeated while HOLD stalls.
- The product is the low 32 bits of the unsigned product, which is identical for signed operands.

## Timing
- Latency from an accept edge N to `out_valid`:
  - Single-cycle ops: `out_valid` at N+2; `redirect` coincides with it.
  - MUL: `out_valid` at N+1+MUL_ITERS (N+33).
- Throughput: one non-MUL op every 2 cycles when `out_ready` is held high.
- Outputs and data are stable while `out_valid`=1 and `out_ready`=0.
- Reset values:
  - state IDLE.
  - `in_ready`=0 while `rst` is asserted.
  - `out_valid`=0, `redirect`=0, `redirect_pc`=0, `out_result`=0, `out_rd`=0, `out_we`=0.
  - `alu_ctr`=0000, `alu_asrc`=0, `alu_bsrc`=00, all `alu_*` operands 0.
- `rst` during MUL or HOLD aborts the op: no `out_valid` and no `redirect`.
- Simultaneous `out_ready` and `in_valid` in HOLD: the result drains and the new op is captured on the same edge.
- mcand shifts are truncated to 32 bits; no overflow flag is produced.

## Structure
- Shared package `ex_pkg` contains:
  - the op-class enum;
  - ALU control constants ADD, SUB, SLT, SLTU, OR, PASSB (1111);
  - ASrc/BSrc select constants;
  - the state enum.
- Sub-module `ex_mul_iter` holds acc/mcand/mplier/cnt and exposes `start`, `busy`, `done`, `product`. The FSM and the ALU interface stay in `ex_ctrl`.

## Test plan
- ADDI with busA=5, imm=7 accepted at cycle 0 -> `alu_ctr`=0000 and `alu_bsrc`=10 at cycle 1; `out_valid`, `out_result`=12 and `out_we`=1 at cycle 2.
- BEQ with busA=busB=9, pc=0x100, imm=0x20 -> `redirect`=1 for exactly one cycle with `redirect_pc`=0x120 and `out_we`=0. Repeat with busB=8 -> `redirect` stays 0.
- MUL with busA=0xFFFFFFFF, busB=3 -> `in_ready`=0 for 32 cycles; `out_result`=0xFFFFFFFD at cycle 33.
- HOLD with `out_ready` low for 5 cycles -> result is stable, `in_ready`=0, and JAL `redirect` pulses only once. Then `out_ready` and `in_valid` go high together -> drain and capture on the same edge.
- Assert `rst` at iteration 10 of a MUL -> all outputs take reset values immediately. After release, an OR with busA=0xF0, busB=0x0F yields 0xFF.
